// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, including the fetch-queue entry that sits between IF and ID.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t next_pc;
    } ifq_entry_t;

    localparam int IFQ_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/if_id_fifo_if.sv
// Bundle of the IF->ID fetch-queue signals, with a design-side and a bench-side view.
interface if_id_fifo_if
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input logic CLK
);
    logic                       nRST;
    logic                       ihit;
    word_t                      instr_i;
    word_t                      next_pc_i;
    logic                       freeze;
    logic                       flush;
    word_t                      instr_o;
    word_t                      next_pc_o;
    logic                       valid_o;
    logic                       full_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport if_id_fifo (
        input  CLK, nRST, ihit, instr_i, next_pc_i, freeze, flush,
        output instr_o, next_pc_o, valid_o, full_o, count_o
    );

    modport tb (
        input  CLK, instr_o, next_pc_o, valid_o, full_o, count_o,
        output nRST, ihit, instr_i, next_pc_i, freeze, flush
    );

endinterface

// File: rtl/if_id_fifo.sv
// Small circular buffer decoupling instruction fetch from decode; head is presented
// combinationally from registered storage, so there is no instr_i -> instr_o path.
module if_id_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH         = IFQ_DEPTH_DEFAULT,
    parameter bit ZERO_ON_EMPTY = 1'b1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       ihit,
    input  word_t                      instr_i,
    input  word_t                      next_pc_i,
    input  logic                       freeze,
    input  logic                       flush,
    output word_t                      instr_o,
    output word_t                      next_pc_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    ifq_entry_t        mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    ifq_entry_t        head;
    ifq_entry_t        shown;
    logic              enq;
    logic              deq;

    // Handshake: ihit offers an entry, taken when enq is high (not full, or a
    // dequeue frees a slot the same cycle); ID consumes the head whenever
    // valid_o is high and it is not frozen. flush wins over both sides.
    assign valid_o = (count != '0);
    assign full_o  = (count == DEPTH_C);
    assign count_o = count;
    assign deq     = valid_o & ~freeze & ~flush;
    assign enq     = ihit & ~flush & (~full_o | deq);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{instr: instr_i, next_pc: next_pc_i};
                wr_ptr      <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    generate
        if (ZERO_ON_EMPTY) begin : g_zero
            assign shown = valid_o ? head : '0;
        end else begin : g_hold
            // Remembers the most recent head so an empty queue keeps showing it.
            ifq_entry_t last_q;
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    last_q <= '0;
                end else if (valid_o) begin
                    last_q <= head;
                end
            end
            assign shown = valid_o ? head : last_q;
        end
    endgenerate

    always_comb begin
        instr_o   = shown.instr;
        next_pc_o = shown.next_pc;
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: three depths driven in lockstep against a queue-based reference.
module tb_if_id_fifo;

    logic        clk;
    logic        nrst;
    logic        ihit;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        freeze;
    logic        flush;

    wire  [31:0] io  [3];
    wire  [31:0] npo [3];
    wire         vo  [3];
    wire         fo  [3];
    wire  [3:0]  cnt [3];
    wire  [0:0]  c0;
    wire  [1:0]  c1;
    wire  [1:0]  c2;

    int          dep [3] = '{1, 2, 3};
    logic [63:0] exp_q [3][$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign cnt[0] = {3'b0, c0};
    assign cnt[1] = {2'b0, c1};
    assign cnt[2] = {2'b0, c2};

    if_id_fifo #(.DEPTH(1)) u_d1 (
        .CLK(clk), .nRST(nrst), .ihit(ihit), .instr_i(instr), .next_pc_i(npc),
        .freeze(freeze), .flush(flush), .instr_o(io[0]), .next_pc_o(npo[0]),
        .valid_o(vo[0]), .full_o(fo[0]), .count_o(c0)
    );
    if_id_fifo #(.DEPTH(2)) u_d2 (
        .CLK(clk), .nRST(nrst), .ihit(ihit), .instr_i(instr), .next_pc_i(npc),
        .freeze(freeze), .flush(flush), .instr_o(io[1]), .next_pc_o(npo[1]),
        .valid_o(vo[1]), .full_o(fo[1]), .count_o(c1)
    );
    if_id_fifo #(.DEPTH(3)) u_d3 (
        .CLK(clk), .nRST(nrst), .ihit(ihit), .instr_i(instr), .next_pc_i(npc),
        .freeze(freeze), .flush(flush), .instr_o(io[2]), .next_pc_o(npo[2]),
        .valid_o(vo[2]), .full_o(fo[2]), .count_o(c2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: a FIFO of at most dep[i] entries, applied once per rising edge.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit has, dq, eq;
            has = exp_q[i].size() != 0;
            dq  = has && !freeze && !flush;
            eq  = ihit && !flush && ((exp_q[i].size() < dep[i]) || dq);
            if (!nrst || flush) begin
                exp_q[i].delete();
            end else begin
                if (dq) void'(exp_q[i].pop_front());
                if (eq) exp_q[i].push_back({instr, npc});
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            logic [63:0] hd;
            int          sz;
            sz = exp_q[i].size();
            hd = (sz != 0) ? exp_q[i][0] : 64'h0;
            check($sformatf("%s.d%0d.valid", tag, dep[i]), 64'(vo[i]), 64'(sz != 0));
            check($sformatf("%s.d%0d.full", tag, dep[i]), 64'(fo[i]), 64'(sz == dep[i]));
            check($sformatf("%s.d%0d.count", tag, dep[i]), 64'(cnt[i]), 64'(sz));
            check($sformatf("%s.d%0d.head", tag, dep[i]), {io[i], npo[i]}, hd);
        end
    endtask

    // Driver: apply inputs, let one rising edge happen, check 1 time unit later.
    task automatic cyc(input string tag, input logic ih, input logic [31:0] ins,
                       input logic fr, input logic fl);
        ihit   = ih;
        instr  = ins;
        npc    = ins + 32'd4;
        freeze = fr;
        flush  = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        nrst = 1'b0; ihit = 1'b0; instr = '0; npc = '0; freeze = 1'b0; flush = 1'b0;
        #1;
        check_all("reset_hold");
        cyc("reset_edge", 1'b1, 32'hdead_beef, 1'b0, 1'b0);
        nrst = 1'b1;

        // Fill while frozen, third offer dropped on DEPTH=2, then drain
        cyc("fill1", 1'b1, 32'h1111_1111, 1'b1, 1'b0);
        cyc("fill2", 1'b1, 32'h2222_2222, 1'b1, 1'b0);
        check("fill.d2.explicit_full", 64'(fo[1]), 64'd1);
        cyc("fill3_drop", 1'b1, 32'h3333_3333, 1'b1, 1'b0);
        check("fill.d2.head_is_first", 64'(io[1]), 64'h1111_1111);
        // Full + dequeue + enqueue in the same cycle
        cyc("full_swap", 1'b1, 32'h4444_4444, 1'b0, 1'b0);
        check("full_swap.d2.head", 64'(io[1]), 64'h2222_2222);
        cyc("drain1", 1'b0, 32'h0, 1'b0, 1'b0);
        check("drain1.d2.head", 64'(io[1]), 64'h4444_4444);
        cyc("drain2", 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("drain3", 1'b0, 32'h0, 1'b0, 1'b0);

        // Flush beats ihit and freeze
        cyc("pre_flush1", 1'b1, 32'h5555_5555, 1'b1, 1'b0);
        cyc("pre_flush2", 1'b1, 32'h6666_6666, 1'b1, 1'b0);
        cyc("flush", 1'b1, 32'h7777_7777, 1'b1, 1'b1);
        check("flush.d2.instr_zero", 64'(io[1]), 64'h0);
        cyc("post_flush", 1'b0, 32'h0, 1'b0, 1'b0);

        // Stream with intermittent freeze to wrap the DEPTH=3 pointers
        for (int k = 0; k < 7; k++) begin
            cyc($sformatf("wrap%0d", k), 1'b1, 32'h100 + k, (k % 3) == 1, 1'b0);
        end
        for (int k = 0; k < 4; k++) cyc("wrap_drain", 1'b0, 32'h0, 1'b0, 1'b0);

        // Back-to-back throughput; DEPTH=1 must be valid every cycle
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("thru%0d", k), 1'b1, 32'h200 + k, 1'b0, 1'b0);
            check($sformatf("thru%0d.d1.instr", k), 64'(io[0]), 64'(32'h200 + k));
        end

        // Asynchronous reset between edges with occupancy present
        cyc("pre_rst1", 1'b1, 32'h8888_8888, 1'b1, 1'b0);
        cyc("pre_rst2", 1'b1, 32'h9999_9999, 1'b1, 1'b0);
        #2;
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        #1;
        check_all("async_rst");
        cyc("rst_low_edge", 1'b1, 32'habcd_0000, 1'b0, 1'b0);
        nrst = 1'b1;
        cyc("first_after_rst", 1'b1, 32'habcd_0001, 1'b1, 1'b0);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            cyc($sformatf("rnd%0d", k), $urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_fifo.md
IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered fetch entries (legal range 1..8, any integer, not restricted to powers of two).
REQ-002 SHALL have parameter ZERO_ON_EMPTY, default 1, which drives instr_o/next_pc_o to 0 when empty (1) or holds the last head value (0).
REQ-003 SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ihit  input  1  fetch presents a valid instruction (enqueue request).
REQ-006 SHALL have port instr_i  input  32 (word_t)  fetched instruction.
REQ-007 SHALL have port next_pc_i  input  32 (word_t)  PC+4 of the fetched instruction.
REQ-008 SHALL have port freeze  input  1  ID stage stalled; no dequeue this cycle.
REQ-009 SHALL have port flush  input  1  discard all buffered entries (branch/jump redirect).
REQ-010 SHALL have port instr_o  output  32 (word_t)  head-entry instruction to ID.
REQ-011 SHALL have port next_pc_o  output  32 (word_t)  head-entry PC+4 to ID.
REQ-012 SHALL have port valid_o  output  1  head entry valid.
REQ-013 SHALL have port full_o  output  1  occupancy == DEPTH; fetch must stall PC.
REQ-014 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 SHALL compute deq = valid_o & ~freeze & ~flush.
REQ-016 SHALL compute enq = ihit & ~flush & (~full_o | deq); enqueue into a full buffer is accepted only when a dequeue occurs in the same cycle.
REQ-017 SHALL have a 1-cycle latency: an entry enqueued at edge N appears on instr_o/next_pc_o after edge N when the buffer was empty; no combinational path from instr_i to instr_o.
REQ-018 SHALL present entries strictly in FIFO order; head is the entry at rd_ptr.
REQ-019 SHALL update count as +1 on enq only, -1 on deq only, unchanged on both or neither.
REQ-020 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
REQ-021 SHALL, on flush, set count, rd_ptr, and wr_ptr to 0 at the next edge; flush overrides a same-cycle ihit and freeze.
REQ-022 SHALL drive valid_o = (count != 0) and full_o = (count == DEPTH), both from registered state.
REQ-023 SHALL, when empty and ZERO_ON_EMPTY=1, drive instr_o=0 (nop) and next_pc_o=0.
REQ-024 SHALL silently drop ihit when full_o=1 and no deq occurs; upstream is responsible for holding the instruction.
REQ-025 SHALL sustain one instruction per cycle with DEPTH=1 when ihit=1 and freeze=0 continuously.

Reset
REQ-026 SHALL, while nRST=0, asynchronously force count=0, rd_ptr=0, wr_ptr=0, and all storage to 0.
REQ-027 SHALL, during reset, produce outputs valid_o=0, full_o=0, count_o=0, instr_o=0, and next_pc_o=0.
REQ-028 SHALL discard in-flight entries on reset mid-operation, and SHALL accept the first ihit on the first rising edge after nRST deasserts.

Structure
REQ-029 SHALL take word_t from cpu_types_pkg.
REQ-030 SHALL add typedef ifq_entry_t (packed struct: instr, next_pc) to cpu_types_pkg.
REQ-031 SHALL add IFQ_DEPTH_DEFAULT = 2 to cpu_types_pkg.
REQ-032 SHALL be a single module with no sub-module; storage is an array of ifq_entry_t indexed by pointers.
REQ-033 SHALL be paired with a new interface if_id_fifo_if providing modports if_id_fifo and tb.

Verification
REQ-034 SHALL cover fill: DEPTH=2, freeze=1, ihit=1 with instr 0x11111111 then 0x22222222 -> full_o=1 and count_o=2 after 2 edges; a third ihit (0x33333333) is dropped; releasing freeze outputs 0x11111111 then 0x22222222.
REQ-035 SHALL cover simultaneous enq/deq when full: DEPTH=2 full, freeze=0, ihit=1 with 0x33333333 -> count_o stays 2, head advances, and 0x33333333 emerges third.
REQ-036 SHALL cover flush priority: count_o=2, flush=1 with ihit=1 and freeze=1 -> next edge count_o=0, valid_o=0, instr_o=0; the ihit entry is not stored.
REQ-037 SHALL cover wrap-around: DEPTH=3, stream 7 instructions with intermittent freeze -> output order is identical to input order across pointer wraps.
REQ-038 SHALL cover throughput: DEPTH=1, ihit=1 and freeze=0 for 10 cycles with incrementing instr -> 10 consecutive valid outputs with no bubble.
REQ-039 SHALL cover async reset: assert nRST=0 between clock edges with count_o=2 -> outputs zero immediately without waiting for CLK.
